// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared opcode encoding, datapath width and the ALU function
// used by the round-robin shared-ALU scheduler.
package alu_sched_pkg;

  localparam int DW = 8;

  typedef enum logic [2:0] {
    OP_PASS_A = 3'b000,
    OP_PASS_B = 3'b001,
    OP_XOR    = 3'b010,
    OP_XNOR   = 3'b011,
    OP_ADD    = 3'b100,
    OP_SUB    = 3'b101,
    OP_SHL    = 3'b110,
    OP_SHR    = 3'b111
  } alu_op_e;

  // Returns {carry, result}. Carry is the adder carry-out, the subtract
  // borrow, or the bit shifted out; zero for the logic/pass opcodes.
  function automatic logic [DW:0] alu_eval(input alu_op_e op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW:0] sum;
    logic [DW:0] diff;
    logic [DW:0] res;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};   // bit DW set exactly when a < b
    case (op)
      OP_PASS_A: res = {1'b0, a};
      OP_PASS_B: res = {1'b0, b};
      OP_XOR:    res = {1'b0, a ^ b};
      OP_XNOR:   res = {1'b0, ~(a ^ b)};
      OP_ADD:    res = sum;
      OP_SUB:    res = diff;
      OP_SHL:    res = {a[DW-1], a[DW-2:0], 1'b0};
      OP_SHR:    res = {a[0], 1'b0, a[DW-1:1]};
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Grants the first asserted
// request found searching upward from ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  // Candidate index for each search offset, already wrapped.
  logic [IDW-1:0] cand [NREQ];
  logic           found;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand[gi] = IDW'((int'(ptr) + gi) % NREQ);
  end

  // Priority search in offset order; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[cand[k]]) begin
        found            = 1'b1;
        grant[cand[k]]   = 1'b1;
        grant_idx        = cand[k];
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: NREQ requesters share one 8-bit ALU through a round-robin
// arbiter and a two-stage (operand, result) pipeline with full backpressure.
// Optional per-requester grant counters: define ALU_RR_SCHED_STATS_EN.
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [3*NREQ-1:0]   req_opcode,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_data,
  output logic                rsp_zero,
  output logic                rsp_carry
`ifdef ALU_RR_SCHED_STATS_EN
  ,
  input  logic                clr_stats,
  output logic [16*NREQ-1:0]  grant_cnt
`endif
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            s2_en;
  logic            s1_free;
  logic            accept;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [IDW-1:0]  rr_ptr_next;

  logic            s1_valid_reg;
  logic [IDW-1:0]  s1_id_reg;
  alu_op_e         s1_op_reg;
  logic [DW-1:0]   s1_a_reg;
  logic [DW-1:0]   s1_b_reg;

  logic            rsp_valid_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [DW-1:0]   rsp_data_reg;
  logic            rsp_zero_reg;
  logic            rsp_carry_reg;
  logic [DW:0]     alu_res;

  logic [2:0]      op_arr [NREQ];
  logic [DW-1:0]   a_arr  [NREQ];
  logic [DW-1:0]   b_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_opcode[3*gi +: 3];
    assign a_arr[gi]  = req_a[DW*gi +: DW];
    assign b_arr[gi]  = req_b[DW*gi +: DW];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // S2 advances when the response slot is empty or being consumed; S1 can
  // take a new op when it is empty or draining into S2 this cycle.
  assign s2_en       = !rsp_valid_reg || rsp_ready;
  assign s1_free     = !s1_valid_reg || s2_en;
  // Gated by rst_n so nothing looks accepted while reset is held.
  assign req_ready   = rst_n ? (grant & {NREQ{s1_free}}) : '0;
  assign accept      = |(req_valid & req_ready);
  assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign alu_res     = alu_eval(s1_op_reg, s1_a_reg, s1_b_reg);

  // Operand stage and round-robin pointer: capture the granted op on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_id_reg    <= '0;
      s1_op_reg    <= OP_PASS_A;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      rr_ptr_reg   <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_id_reg    <= grant_idx;
      s1_op_reg    <= alu_op_e'(op_arr[grant_idx]);
      s1_a_reg     <= a_arr[grant_idx];
      s1_b_reg     <= b_arr[grant_idx];
      rr_ptr_reg   <= rr_ptr_next;
    end else if (s2_en) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Result stage: load ALU output from S1, or retire the held response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
      rsp_zero_reg  <= 1'b0;
      rsp_carry_reg <= 1'b0;
    end else if (s1_valid_reg && s2_en) begin
      rsp_valid_reg <= 1'b1;
      rsp_id_reg    <= s1_id_reg;
      rsp_data_reg  <= alu_res[DW-1:0];
      rsp_zero_reg  <= (alu_res[DW-1:0] == '0);
      rsp_carry_reg <= alu_res[DW];
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign rsp_carry = rsp_carry_reg;

`ifdef ALU_RR_SCHED_STATS_EN
  logic [15:0] cnt_reg [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    // Saturating accept counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg[gi] <= '0;
      end else if (clr_stats) begin
        cnt_reg[gi] <= '0;
      end else if (req_valid[gi] && req_ready[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
        cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
      end
    end
    assign grant_cnt[16*gi +: 16] = cnt_reg[gi];
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: directed and randomized checks of alu_rr_sched against a
// queue-based reference (expected responses in acceptance order).
module tb_alu_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_opcode;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_zero;
  logic              rsp_carry;
`ifdef ALU_RR_SCHED_STATS_EN
  logic              clr_stats;
  logic [16*NREQ-1:0] grant_cnt;
`endif

  alu_rr_sched #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry)
`ifdef ALU_RR_SCHED_STATS_EN
    ,
    .clr_stats  (clr_stats),
    .grant_cnt  (grant_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic       pend_v  [NREQ];
  logic [2:0] pend_op [NREQ];
  logic [7:0] pend_a  [NREQ];
  logic [7:0] pend_b  [NREQ];
  logic [11:0] exp_q [$];
  int acc_order [$];
  int mdl_ptr = 0;
  int n_acc = 0;
  int n_rsp = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference ALU from the opcode table, plain integer arithmetic.
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    logic c;
    ia = int'(a); ib = int'(b); c = 1'b0; r = 0;
    case (op)
      3'd0: r = ia;
      3'd1: r = ib;
      3'd2: r = ia ^ ib;
      3'd3: r = 255 - (ia ^ ib);
      3'd4: begin r = ia + ib; c = (r > 255); end
      3'd5: begin c = (ia < ib); r = ia - ib + 256; end
      3'd6: begin r = ia * 2; c = (ia >= 128); end
      default: begin r = ia / 2; c = (ia % 2) == 1; end
    endcase
    return {c, 8'(r % 256)};
  endfunction

  task automatic clear_pend();
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0; pend_op[i] = 3'd0; pend_a[i] = 8'd0; pend_b[i] = 8'd0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = pend_v[i];
      req_opcode[3*i +: 3] = pend_op[i];
      req_a[8*i +: 8]     = pend_a[i];
      req_b[8*i +: 8]     = pend_b[i];
    end
  endtask

  task automatic gen_pending(input int pct, input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i] && !pend_v[i] && ($urandom_range(0, 99) < pct)) begin
        pend_v[i]  = 1'b1;
        pend_op[i] = 3'($urandom_range(0, 7));
        pend_a[i]  = 8'($urandom);
        pend_b[i]  = 8'($urandom);
      end
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (pend_v[(mdl_ptr + k) % NREQ]) return (mdl_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend_v[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Sample settled outputs, score the response and request handshakes that
  // the coming rising edge will complete.
  task automatic observe();
    int g;
    logic [8:0] r;
    logic [11:0] e;
    #1;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_rsp", 16'(rsp_valid), 16'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp", 16'({rsp_id, rsp_zero, rsp_carry, rsp_data}), 16'(e));
        n_rsp++;
      end
    end
    if (req_ready !== '0) begin
      g = model_grant();
      if (g < 0) chk("ready_without_valid", 16'(req_ready), 16'd0);
      else begin
        chk("grant", 16'(req_ready), 16'(1 << g));
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            r = ref_alu(pend_op[i], pend_a[i], pend_b[i]);
            exp_q.push_back({2'(i), (r[7:0] == 8'd0), r[8], r[7:0]});
            mdl_ptr = (i + 1) % NREQ;
            acc_order.push_back(i);
            n_acc++;
            pend_v[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_pend(); apply();
    exp_q.delete(); acc_order.delete();
    mdl_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || any_pend()) && b < 60) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      apply(); observe();
      b++;
    end
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic directed_op(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] ed, input logic ez, input logic ec);
    @(negedge clk);
    rsp_ready = 1'b1;
    pend_v[r] = 1'b1; pend_op[r] = op; pend_a[r] = a; pend_b[r] = b;
    apply(); observe();
    chk("dir_ready", 16'(req_ready), 16'(1 << r));
    @(negedge clk); apply(); observe();
    chk("dir_lat1", 16'(rsp_valid), 16'd0);
    @(negedge clk); apply(); observe();
    chk("dir_rsp", 16'({rsp_valid, 2'(rsp_id), rsp_zero, rsp_carry, rsp_data}),
        16'({1'b1, 2'(r), ez, ec, ed}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0;
    logic [7:0] hold;
    clear_pend(); apply();
    rsp_ready = 1'b1;
`ifdef ALU_RR_SCHED_STATS_EN
    clr_stats = 1'b0;
`endif
    // Reset state, with every requester asserting valid.
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_id",    16'(rsp_id),    16'd0);
    chk("rst_rsp_data",  16'(rsp_data),  16'd0);
    chk("rst_rsp_zero",  16'(rsp_zero),  16'd0);
    chk("rst_rsp_carry", 16'(rsp_carry), 16'd0);
    chk("rst_req_ready", 16'(req_ready), 16'd0);
    @(negedge clk);
    apply();
    rst_n = 1'b1;

    // Single op and flag cases.
    directed_op(2, 3'b100, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1);
    directed_op(0, 3'b101, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1);
    directed_op(1, 3'b011, 8'h55, 8'h55, 8'hFF, 1'b0, 1'b0);
    directed_op(3, 3'b010, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0);
    directed_op(0, 3'b111, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
    directed_op(2, 3'b110, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1);
    drain();

    // Round-robin with all requesters continuously valid.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      gen_pending(100, 4'hF); apply(); observe();
    end
    chk("rr_count", 16'(acc_order.size()), 16'd12);
    for (int k = 0; k < acc_order.size(); k++) chk("rr_order", 16'(acc_order[k]), 16'(k % NREQ));
    drain();

    // Backpressure: response stalled for five cycles.
    do_reset();
    a0 = n_acc; r0 = n_rsp; hold = 8'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      gen_pending(100, 4'b0010); apply(); observe();
      if (c >= 2) chk("bp_ready_zero", 16'(req_ready), 16'd0);
      if (c == 2) begin
        chk("bp_rsp_valid", 16'(rsp_valid), 16'd1);
        hold = rsp_data;
      end
      if (c > 2) chk("bp_hold", 16'(rsp_data), 16'(hold));
    end
    chk("bp_accepts", 16'(n_acc - a0), 16'd2);
    drain();
    chk("bp_no_loss", 16'(n_rsp - r0), 16'(n_acc - a0));

    // Reset asserted with both stages full.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      gen_pending(100, 4'b0010); apply(); observe();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("mid_rst_req_ready", 16'(req_ready), 16'd0);
    clear_pend(); apply();
    exp_q.delete(); acc_order.delete(); mdl_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      apply(); observe();
      chk("post_rst_quiet", 16'(rsp_valid), 16'd0);
    end
    @(negedge clk);
    gen_pending(100, 4'hF); apply(); observe();
    chk("post_rst_ptr0", 16'(req_ready), 16'd1);
    drain();

    // Randomized traffic with random response backpressure.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rsp_ready = ($urandom_range(0, 3) != 0);
      gen_pending(30, 4'hF); apply(); observe();
    end
    drain();

`ifdef ALU_RR_SCHED_STATS_EN
    // Grant counters: three accepts on req 0, one on req 3, then clear.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      gen_pending(100, (k < 3) ? 4'b0001 : 4'b1000); apply(); observe();
    end
    drain();
    @(negedge clk); #1;
    chk("cnt0", grant_cnt[15:0],  16'd3);
    chk("cnt1", grant_cnt[31:16], 16'd0);
    chk("cnt2", grant_cnt[47:32], 16'd0);
    chk("cnt3", grant_cnt[63:48], 16'd1);
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    #1;
    chk("cnt_clr", 16'(grant_cnt != '0), 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
